// File: rtl/div_iter_pkg.sv
// -----------------------------------------------------------------------------
// div_iter_pkg
// Shared definitions for the iterative divider: FSM state encoding, handshake
// level names and the double-width result bus type used by EX.
// -----------------------------------------------------------------------------
package div_iter_pkg;

    // Default operand width of the EX-stage divider.
    localparam int DIV_WIDTH_DEFAULT = 32;

    // Divider FSM states.
    typedef enum logic [1:0] {
        DIV_FREE   = 2'b00,  // idle, waiting for a request
        DIV_BYZERO = 2'b01,  // divisor (or dividend magnitude) is zero
        DIV_ON     = 2'b10,  // iterating, one quotient bit per cycle
        DIV_END    = 2'b11   // result presented until EX drops start_i
    } div_state_e;

    // Handshake level names.
    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;
    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;

    // {remainder, quotient} at the default width.
    typedef logic [2*DIV_WIDTH_DEFAULT-1:0] DoubleRegBus;

endpackage : div_iter_pkg

// File: rtl/div_if.sv
// -----------------------------------------------------------------------------
// div_if
// EX <-> divider request/result bundle.
//
// Handshake: EX raises start_i with operands and keeps it high until it has
// consumed the result. The divider samples operands only on the accept edge
// (FREE, start_i=1, annul_i=0). ready_o=1 means result_o is valid and holds
// stable while start_i stays high; EX dropping start_i releases the divider,
// which clears ready_o and result_o on the following edge. annul_i aborts an
// in-flight division without ever raising ready_o.
//
// Signals: signed_div_i, opdata1_i (dividend), opdata2_i (divisor), start_i,
//          annul_i (EX -> divider); result_o {rem,quot}, ready_o, busy_o
//          (divider -> EX).
// Modports: master = EX side, slave = divider side.
// -----------------------------------------------------------------------------
interface div_if #(
    parameter int WIDTH = 32
);
    logic                 signed_div_i;
    logic [WIDTH-1:0]     opdata1_i;
    logic [WIDTH-1:0]     opdata2_i;
    logic                 start_i;
    logic                 annul_i;
    logic [2*WIDTH-1:0]   result_o;
    logic                 ready_o;
    logic                 busy_o;

    modport master (
        output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        input  result_o, ready_o, busy_o
    );

    modport slave (
        input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        output result_o, ready_o, busy_o
    );
endinterface : div_if

// File: rtl/div_iter_lz_count.sv
// -----------------------------------------------------------------------------
// lz_count
// Combinational leading-zero counter. Only built when DIV_EARLY_OUT_EN is
// defined; without it the divider carries no LZC logic at all.
// Ports: i_data  (WIDTH)  value to scan
//        o_count (CNT_W)  number of leading zeros; WIDTH for an all-zero input
// -----------------------------------------------------------------------------
`ifdef DIV_EARLY_OUT_EN
module lz_count #(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] i_data,
    output logic [CNT_W-1:0] o_count
);
    // Scan LSB to MSB; the last set bit seen is the most significant one.
    always_comb begin
        o_count = CNT_W'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (i_data[i]) begin
                o_count = CNT_W'(WIDTH - 1 - i);
            end
        end
    end
endmodule : lz_count
`endif

// File: rtl/div_iter.sv
// -----------------------------------------------------------------------------
// div_iter
// Multi-cycle restoring divider for the EX stage (DIV / DIVU).
// Operands are latched on the accept edge, converted to magnitudes in signed
// mode, divided one quotient bit per cycle MSB first, then sign-fixed.
// Latency from the accept edge to ready_o: N+2 cycles (N = WIDTH), 2 cycles
// for a zero divisor.
//
// Optional feature macro: DIV_EARLY_OUT_EN
//   Pre-shifts the dividend magnitude by its leading-zero count so only
//   WIDTH-lz iterations run; a zero dividend magnitude takes the zero-result
//   path. Results are identical with or without it, only latency changes.
//
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous active-low reset
//   bus          div_if.slave request/result bundle
//   o_dbg_state  current FSM state, for observation only
// -----------------------------------------------------------------------------
module div_iter
    import div_iter_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic       clk,
    input  logic       rst,
    div_if.slave       bus,
    output div_state_e o_dbg_state
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    div_state_e         r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_dvd;     // dividend shifts out MSB first, quotient shifts in
    logic [WIDTH-1:0]   r_rem;     // partial remainder
    logic [WIDTH-1:0]   r_dsr;     // divisor magnitude
    logic               r_neg_q;   // negate quotient at fix-up
    logic               r_neg_r;   // negate remainder at fix-up
    logic [2*WIDTH-1:0] r_result;
    logic               r_ready;

    // -------------------------------------------------------------------------
    // Accept-time operand conditioning
    // -------------------------------------------------------------------------
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [WIDTH-1:0]   w_dvd_init;
    logic               w_dvd_zero;
    logic [CNT_W-1:0]   w_n;       // cnt value at which the fix-up cycle runs

    assign w_a_neg = bus.signed_div_i & bus.opdata1_i[WIDTH-1];
    assign w_b_neg = bus.signed_div_i & bus.opdata2_i[WIDTH-1];
    // Two's complement magnitude; MIN maps onto itself, which is the correct
    // unsigned magnitude 2^(WIDTH-1).
    assign w_a_mag = w_a_neg ? -bus.opdata1_i : bus.opdata1_i;
    assign w_b_mag = w_b_neg ? -bus.opdata2_i : bus.opdata2_i;

`ifdef DIV_EARLY_OUT_EN
    logic [CNT_W-1:0]   w_lz;
    logic [CNT_W-1:0]   r_n;

    lz_count #(
        .WIDTH (WIDTH)
    ) u_lz_count (
        .i_data  (w_a_mag),
        .o_count (w_lz)
    );

    // Leading zeros of the dividend would only produce leading zero quotient
    // bits; skip them by starting with the first set bit at the MSB.
    assign w_dvd_init = w_a_mag << w_lz;
    assign w_dvd_zero = (w_a_mag == '0);
    assign w_n        = r_n;
`else
    assign w_dvd_init = w_a_mag;
    assign w_dvd_zero = 1'b0;
    assign w_n        = CNT_W'(WIDTH);
`endif

    // -------------------------------------------------------------------------
    // One restoring step: trial-subtract |divisor| from {rem, next dividend bit}
    // -------------------------------------------------------------------------
    logic [WIDTH:0]     w_part;
    logic               w_fit;
    logic [WIDTH-1:0]   w_diff;
    logic [WIDTH-1:0]   w_rem_next;
    logic [WIDTH-1:0]   w_dvd_next;

    assign w_part = {r_rem, r_dvd[WIDTH-1]};
    assign w_fit  = (w_part >= {1'b0, r_dsr});
    // When the subtraction fits, the difference is below |divisor| and so
    // fits in WIDTH bits; the low-bit subtraction is exact.
    assign w_diff = w_part[WIDTH-1:0] - r_dsr;
    // When it does not fit, {rem,bit} < |divisor| so its top bit is zero.
    assign w_rem_next = w_fit ? w_diff : w_part[WIDTH-1:0];
    assign w_dvd_next = {r_dvd[WIDTH-2:0], w_fit};

    // Sign fix-up: quotient negative iff signs differ, remainder follows the
    // dividend. MIN / -1 wraps to MIN naturally.
    logic [WIDTH-1:0]   w_quot_fix;
    logic [WIDTH-1:0]   w_rem_fix;

    assign w_quot_fix = r_neg_q ? -r_dvd : r_dvd;
    assign w_rem_fix  = r_neg_r ? -r_rem : r_rem;

    // -------------------------------------------------------------------------
    // FSM and datapath
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= DIV_FREE;
            r_cnt    <= '0;
            r_dvd    <= '0;
            r_rem    <= '0;
            r_dsr    <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_result <= '0;
            r_ready  <= DivResultNotReady;
`ifdef DIV_EARLY_OUT_EN
            r_n      <= '0;
`endif
        end else begin
            case (r_state)
                DIV_FREE: begin
                    r_ready  <= DivResultNotReady;
                    r_result <= '0;
                    if (bus.start_i == DivStart && !bus.annul_i) begin
                        r_cnt   <= '0;
                        r_rem   <= '0;
                        r_dvd   <= w_dvd_init;
                        r_dsr   <= w_b_mag;
                        r_neg_q <= w_a_neg ^ w_b_neg;
                        r_neg_r <= w_a_neg;
`ifdef DIV_EARLY_OUT_EN
                        r_n     <= CNT_W'(WIDTH) - w_lz;
`endif
                        // A zero dividend magnitude shares the all-zero result
                        // path with divide-by-zero.
                        if (bus.opdata2_i == '0 || w_dvd_zero) begin
                            r_state <= DIV_BYZERO;
                        end else begin
                            r_state <= DIV_ON;
                        end
                    end
                end

                DIV_BYZERO: begin
                    if (bus.annul_i) begin
                        r_state <= DIV_FREE;
                    end else begin
                        r_dvd   <= '0;
                        r_rem   <= '0;
                        r_state <= DIV_END;
                    end
                end

                DIV_ON: begin
                    if (bus.annul_i) begin
                        r_cnt   <= '0;
                        r_state <= DIV_FREE;
                    end else if (r_cnt == w_n) begin
                        // All quotient bits are in; apply signs and present.
                        r_dvd   <= w_quot_fix;
                        r_rem   <= w_rem_fix;
                        r_cnt   <= '0;
                        r_state <= DIV_END;
                    end else begin
                        r_dvd   <= w_dvd_next;
                        r_rem   <= w_rem_next;
                        r_cnt   <= r_cnt + 1'b1;
                    end
                end

                DIV_END: begin
                    if (bus.start_i == DivStart) begin
                        r_ready  <= DivResultReady;
                        r_result <= {r_rem, r_dvd};
                    end else begin
                        r_ready  <= DivResultNotReady;
                        r_result <= '0;
                        r_state  <= DIV_FREE;
                    end
                end

                default: begin
                    r_state <= DIV_FREE;
                end
            endcase
        end
    end

    assign bus.result_o = r_result;
    assign bus.ready_o  = r_ready;
    assign bus.busy_o   = (r_state == DIV_BYZERO) || (r_state == DIV_ON);
    assign o_dbg_state  = r_state;

endmodule : div_iter

// File: tb/tb_div_iter.sv
// -----------------------------------------------------------------------------
// tb_div_iter
// Self-checking bench for div_iter at WIDTH=32. Expected {rem,quot} values are
// pushed to exp_q when a request is driven and popped when ready_o rises.
// -----------------------------------------------------------------------------
module tb_div_iter;
    import div_iter_pkg::*;

    localparam int W = 32;

    // -------------------------------------------------------------------------
    // Clock / reset
    // -------------------------------------------------------------------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    div_if #(.WIDTH(W)) bus ();
    div_state_e dbg_state;

    div_iter #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    // -------------------------------------------------------------------------
    // Scoreboard
    // -------------------------------------------------------------------------
    logic [2*W-1:0] exp_q[$];
    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference division using plain integer arithmetic (truncating).
    function automatic DoubleRegBus ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic sgn);
        longint sa, sb, q, r;
        if (b == '0) return '0;
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'b0, a});
            sb = longint'({32'b0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[W-1:0], q[W-1:0]};
    endfunction

    // Expected cycles from accept edge to ready_o.
    function automatic int ref_lat(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn);
`ifdef DIV_EARLY_OUT_EN
        logic [W-1:0] mag;
        int lz;
        if (b == '0) return 2;
        mag = (sgn && a[W-1]) ? (~a + 32'd1) : a;
        if (mag == '0) return 2;
        lz = 0;
        while (lz < W && !mag[W-1-lz]) lz++;
        return W - lz + 2;
`else
        if (b == '0) return 2;
        return W + 2;
`endif
    endfunction

    task automatic check_idle(input string tag);
        check_eq({tag, "_result"}, 64'(bus.result_o), 64'd0);
        check_eq({tag, "_ready"},  64'(bus.ready_o),  64'd0);
        check_eq({tag, "_busy"},   64'(bus.busy_o),   64'd0);
        check_eq({tag, "_state"},  64'(dbg_state),    64'(DIV_FREE));
    endtask

    // -------------------------------------------------------------------------
    // Driver: one full request/response transaction
    // -------------------------------------------------------------------------
    task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn,
                           input int hold);
        logic [2*W-1:0] exp;
        int lat, busy_n, want_lat;
        bit seen;
        want_lat = ref_lat(a, b, sgn);
        @(negedge clk);
        bus.opdata1_i    = a;
        bus.opdata2_i    = b;
        bus.signed_div_i = sgn;
        bus.annul_i      = 1'b0;
        bus.start_i      = 1'b1;
        exp_q.push_back(ref_div(a, b, sgn));
        lat = 0; busy_n = 0; seen = 0;
        // c counts rising edges; edge 1 is the accept edge.
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (c == 1) begin
                // Operand changes after accept must not matter.
                bus.opdata1_i    = $urandom;
                bus.opdata2_i    = $urandom;
                bus.signed_div_i = 1'($urandom_range(0, 1));
            end
            if (bus.ready_o) begin
                lat  = c - 1;
                seen = 1;
                break;
            end
            if (bus.busy_o) busy_n++;
        end
        if (!seen) begin
            check_eq("ready_timeout", 64'd0, 64'd1);
            void'(exp_q.pop_front());
        end else begin
            check_eq("latency", 64'(lat), 64'(want_lat));
            check_eq("busy_cycles", 64'(busy_n), 64'(want_lat - 1));
            if (exp_q.size() == 0) begin
                check_eq("queue_empty", 64'd1, 64'd0);
            end else begin
                exp = exp_q.pop_front();
                check_eq("result", bus.result_o, exp);
                for (int h = 1; h <= hold; h++) begin
                    bus.annul_i = (h == 1);  // annul in END must be ignored
                    @(negedge clk);
                    check_eq("hold_result", bus.result_o, exp);
                    check_eq("hold_ready", 64'(bus.ready_o), 64'd1);
                end
            end
        end
        bus.annul_i = 1'b0;
        bus.start_i = 1'b0;
        @(negedge clk);
        check_eq("drop_ready", 64'(bus.ready_o), 64'd0);
        check_eq("drop_result", bus.result_o, 64'd0);
    endtask

    // Annul ten cycles into ON: back to FREE next edge, ready never rises.
    task automatic run_annul();
        @(negedge clk);
        bus.opdata1_i = 32'd100; bus.opdata2_i = 32'd7; bus.signed_div_i = 1'b0;
        bus.start_i = 1'b1; bus.annul_i = 1'b0;
        repeat (11) @(negedge clk);
        check_eq("annul_pre_busy", 64'(bus.busy_o), 64'd1);
        bus.annul_i = 1'b1;
        @(negedge clk);
        check_idle("annul");
        // start with annul held in FREE is ignored.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("annul_free_state", 64'(dbg_state), 64'(DIV_FREE));
            check_eq("annul_free_ready", 64'(bus.ready_o), 64'd0);
        end
        bus.start_i = 1'b0;
        bus.annul_i = 1'b0;
        @(negedge clk);
    endtask

    // Asynchronous reset mid-cycle; end_phase selects reset while in END.
    task automatic run_async_reset(input bit end_phase);
        bit seen;
        @(negedge clk);
        bus.opdata1_i = 32'd1000; bus.opdata2_i = 32'd3; bus.signed_div_i = 1'b0;
        bus.start_i = 1'b1; bus.annul_i = 1'b0;
        if (end_phase) begin
            seen = 0;
            for (int c = 0; c < 100; c++) begin
                @(negedge clk);
                if (bus.ready_o) begin seen = 1; break; end
            end
            check_eq("rst_end_ready", 64'(seen), 64'd1);
            check_eq("rst_end_result", bus.result_o, 64'(ref_div(32'd1000, 32'd3, 1'b0)));
        end else begin
            repeat (8) @(negedge clk);
            check_eq("rst_on_busy", 64'(bus.busy_o), 64'd1);
        end
        #2 rst = 1'b0;
        #1 check_idle(end_phase ? "rst_end" : "rst_on");
        bus.start_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    // -------------------------------------------------------------------------
    // Watchdog
    // -------------------------------------------------------------------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // -------------------------------------------------------------------------
    // Main sequence
    // -------------------------------------------------------------------------
    initial begin
        logic [W-1:0] ra, rb;
        bus.start_i = 1'b0; bus.annul_i = 1'b0; bus.signed_div_i = 1'b0;
        bus.opdata1_i = '0; bus.opdata2_i = '0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_idle("reset");
        rst = 1'b1;
        @(negedge clk);

        run_div(32'd100,        32'd7,        1'b0, 0);
        run_div(32'hFFFF_FFF9,  32'd2,        1'b1, 0);
        run_div(32'd7,          32'hFFFF_FFFE, 1'b1, 0);
        run_div(32'h0000_1234,  32'd0,        1'b0, 0);
        run_div(32'd9,          32'd3,        1'b0, 0);
        run_div(32'h8000_0000,  32'hFFFF_FFFF, 1'b1, 5);
        run_div(32'd5,          32'd3,        1'b0, 0);
        run_div(32'd0,          32'd9,        1'b0, 0);
        run_div(32'hFFFF_FFFF,  32'd1,        1'b0, 0);
        run_div(32'h8000_0000,  32'hFFFF_FFFF, 1'b0, 0);
        run_div(32'hFFFF_FFF9,  32'hFFFF_FFFE, 1'b1, 2);
        run_div(32'hFFFF_FFF9,  32'd0,        1'b1, 1);

        run_annul();
        run_div(32'd100, 32'd7, 1'b0, 0);

        run_async_reset(1'b0);
        run_div(32'd1000, 32'd3, 1'b0, 0);
        run_async_reset(1'b1);
        run_div(32'hDEAD_BEEF, 32'd17, 1'b1, 0);

        for (int i = 0; i < 16; i++) begin
            ra = $urandom;
            if ($urandom_range(0, 3) == 0) ra = ra >> $urandom_range(1, 31);
            rb = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 20)) : 32'($urandom);
            run_div(ra, rb, 1'($urandom_range(0, 1)), $urandom_range(0, 2));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_div_iter
